or_gate_response_checker: RTL and testbench
===========================================

# or_gate_response_checker

Synthesizable response checker for exhaustive N-input OR-gate sweeps. It accepts each applied input vector together with the DUT's output, compares the output against the golden OR reduction, and counts mismatches. It records which of the 2^N_IN vectors have been seen and reports done/pass once all of them are covered. It is the receiving end of the gate-level stimulus sweeps: the stimulus generator drives the DUT, and this block judges the responses on-chip or in simulation.

## Interface
- N_IN, default 4: number of gate inputs; the coverage space is 2^N_IN vectors; legal range 1..6.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; clears all results and enters RUN.
- vec_valid  input  1  vec_in/dut_out are a valid sample this cycle.
- vec_in  input  N_IN  input vector applied to the DUT.
- dut_out  input  1  DUT output for vec_in.
- busy  output  1  high in RUN.
- mismatch  output  1  one-cycle pulse, registered, for a failing sample.
- err_count  output  N_IN+1  number of mismatching samples, saturating at all-ones.
- first_err_valid  output  1  at least one mismatch has been captured since start.
- first_err_vec  output  N_IN  vec_in of the first mismatch.
- done  output  1  all 2^N_IN vectors covered; held until start or reset.
- pass  output  1  valid only while done; high iff err_count==0.

## Operation
- States: IDLE, RUN, DONE.
- Reset (rst_n=0, async) → IDLE. All outputs are 0. Coverage bitmap is cleared.
- IDLE:
  - vec_valid is ignored.
  - start → RUN, with err_count, first_err_*, bitmap and mismatch cleared.
- RUN, per cycle with vec_valid=1:
  - expected = |vec_in.
  - If dut_out != expected: mismatch=1 next cycle, and err_count increments unless it is already all-ones.
  - On the first mismatch since start: latch first_err_vec=vec_in and set first_err_valid. Later mismatches do not change them.
  - Set bitmap[vec_in].
  - Duplicate vectors are rechecked and counted, but add no coverage.
- RUN → DONE on the same edge that sets the last unset bitmap bit, i.e. the sample completing coverage. That sample is still checked and counted.
- DONE:
  - done=1; pass = (err_count==0), where err_count includes the final sample.
  - vec_valid is ignored and counters are frozen.
- start in RUN or DONE: restart, with the same clearing as from IDLE, and go to RUN. Any vec_valid sample in the same cycle as start is discarded.
- start and rst_n low together: reset wins.
- Sample order is unconstrained: Gray, binary, random or with gaps. Any order that covers all vectors completes.
- No timeout. An incomplete sweep stays in RUN indefinitely.

## Timing
- Check latency is 1 cycle. A sample at edge k updates mismatch, err_count, first_err_* and the bitmap at edge k+1 (registered outputs).
- done, pass and the busy fall are visible 1 cycle after the edge accepting the completing sample.
- busy rises 1 cycle after start is sampled.
- mismatch is a single-cycle pulse per failing sample. Back-to-back failing samples give a continuously high mismatch.
- Reset mid-RUN clears everything immediately (asynchronous). The first start after reset begins a fresh sweep.

## Test plan
- Correct DUT, N_IN=4, binary sweep 0..15 with vec_valid on 16 consecutive cycles after start → done=1 and pass=1 one cycle after the 16th sample; err_count=0; mismatch never pulses.
- Faulty DUT stuck-at-1 (dut_out=1 for vec 4'b0000), Gray-order sweep → exactly one mismatch pulse; err_count=1; first_err_vec=4'b0000; done=1; pass=0.
- Stuck-at-0 DUT (dut_out=0 always), sweep 0..15 → err_count=15; first_err_vec=4'b0001; pass=0.
- Duplicates and gaps: send 0..14, then 7 twice, with vec_valid deasserted randomly → busy stays 1 and done=0; sending 15 → done the next cycle with err_count=0.
- Reset during RUN after 8 samples, including 1 mismatch → all outputs 0 immediately; IDLE. A fresh start plus a full correct sweep → pass=1, err_count=0.
- Restart: start asserted in DONE with a concurrent vec_valid → that sample is ignored; counters and bitmap are cleared; a sweep of 15 vectors leaves done=0.

Source files
------------

// File: rtl/or_gate_response_checker.sv
// Response checker for exhaustive N-input OR-gate sweeps: compares each DUT
// sample with the golden OR reduction, counts failures and tracks vector coverage.
module or_gate_response_checker #(
    parameter int N_IN = 4
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_start,
    input  logic            i_vec_valid,
    input  logic [N_IN-1:0] i_vec_in,
    input  logic            i_dut_out,
    output logic            o_busy,
    output logic            o_mismatch,
    output logic [N_IN:0]   o_err_count,
    output logic            o_first_err_valid,
    output logic [N_IN-1:0] o_first_err_vec,
    output logic            o_done,
    output logic            o_pass
);

    // state  | meaning
    // S_IDLE | waiting for start, samples ignored
    // S_RUN  | checking samples, collecting coverage
    // S_DONE | every vector seen, results frozen
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

    localparam int NV = 1 << N_IN;

    state_t          r_state;
    state_t          w_state_next;
    logic [NV-1:0]   r_bitmap;
    logic [NV-1:0]   w_onehot;
    logic [N_IN:0]   r_err_count;
    logic            r_mismatch;
    logic            r_first_err_valid;
    logic [N_IN-1:0] r_first_err_vec;
    logic            w_accept;
    logic            w_fail;
    logic            w_complete;

    // A sample coinciding with start belongs to the abandoned sweep.
    assign w_accept   = (r_state == S_RUN) && i_vec_valid && !i_start;
    assign w_fail     = w_accept && (i_dut_out != (|i_vec_in));
    assign w_onehot   = NV'(1) << i_vec_in;
    assign w_complete = w_accept && (&(r_bitmap | w_onehot));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (i_start) begin
            w_state_next = S_RUN;
        end else begin
            case (r_state)
                S_RUN:   if (w_complete) w_state_next = S_DONE;
                S_IDLE:  w_state_next = S_IDLE;
                S_DONE:  w_state_next = S_DONE;
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        o_busy = (r_state == S_RUN);
        o_done = (r_state == S_DONE);
        o_pass = (r_state == S_DONE) && (r_err_count == '0);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_bitmap          <= '0;
            r_err_count       <= '0;
            r_mismatch        <= 1'b0;
            r_first_err_valid <= 1'b0;
            r_first_err_vec   <= '0;
        end else if (i_start) begin
            r_bitmap          <= '0;
            r_err_count       <= '0;
            r_mismatch        <= 1'b0;
            r_first_err_valid <= 1'b0;
            r_first_err_vec   <= '0;
        end else begin
            r_mismatch <= w_fail;
            if (w_accept) begin
                r_bitmap <= r_bitmap | w_onehot;
            end
            if (w_fail) begin
                if (r_err_count != '1) begin
                    r_err_count <= r_err_count + (N_IN + 1)'(1);
                end
                if (!r_first_err_valid) begin
                    r_first_err_valid <= 1'b1;
                    r_first_err_vec   <= i_vec_in;
                end
            end
        end
    end

    assign o_mismatch        = r_mismatch;
    assign o_err_count       = r_err_count;
    assign o_first_err_valid = r_first_err_valid;
    assign o_first_err_vec   = r_first_err_vec;

endmodule

// File: tb/tb_or_gate_response_checker.sv
// Self-checking bench for or_gate_response_checker (N_IN=4): a reference model
// pushes expected outputs per driven cycle; a monitor pops and compares them.
module tb_or_gate_response_checker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       vec_valid = 1'b0;
    logic [3:0] vec_in = '0;
    logic       dut_out = 1'b0;
    logic       o_busy, o_mismatch, o_first_err_valid, o_done, o_pass;
    logic [4:0] o_err_count;
    logic [3:0] o_first_err_vec;

    int n_checks = 0;
    int n_errors = 0;
    int pulse_cnt = 0;

    typedef struct packed {
        logic       mm;
        logic [4:0] err;
        logic       done;
        logic       pass;
        logic       busy;
        logic       fev;
        logic [3:0] fvec;
    } exp_t;

    exp_t sb_q[$];

    // reference model: 0 idle, 1 run, 2 done
    int          m_state = 0;
    logic [15:0] m_bitmap = '0;
    logic [4:0]  m_err = '0;
    logic        m_fev = 1'b0;
    logic [3:0]  m_fvec = '0;

    or_gate_response_checker #(.N_IN(4)) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_start(start),
        .i_vec_valid(vec_valid),
        .i_vec_in(vec_in),
        .i_dut_out(dut_out),
        .o_busy(o_busy),
        .o_mismatch(o_mismatch),
        .o_err_count(o_err_count),
        .o_first_err_valid(o_first_err_valid),
        .o_first_err_vec(o_first_err_vec),
        .o_done(o_done),
        .o_pass(o_pass)
    );

    always #5 clk = ~clk;

    function automatic logic golden(input logic [3:0] v);
        return |v;
    endfunction

    always @(posedge clk) begin
        exp_t e;
        exp_t a;
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            a = '{o_mismatch, o_err_count, o_done, o_pass, o_busy, o_first_err_valid, o_first_err_vec};
            if (o_mismatch === 1'b1) pulse_cnt++;
            n_checks++;
            if (a !== e) begin
                n_errors++;
                $display("FAIL scoreboard t=%0t got mm=%b err=%0d done=%b pass=%b busy=%b fev=%b fvec=%h exp mm=%b err=%0d done=%b pass=%b busy=%b fev=%b fvec=%h",
                         $time, a.mm, a.err, a.done, a.pass, a.busy, a.fev, a.fvec,
                         e.mm, e.err, e.done, e.pass, e.busy, e.fev, e.fvec);
            end
        end
    end

    task automatic drive(input logic st, input logic v, input logic [3:0] vec, input logic out);
        exp_t e;
        logic mm;
        @(negedge clk);
        start = st; vec_valid = v; vec_in = vec; dut_out = out;
        mm = 1'b0;
        if (st) begin
            m_state = 1; m_bitmap = '0; m_err = '0; m_fev = 1'b0; m_fvec = '0;
        end else if (m_state == 1 && v) begin
            if (out != golden(vec)) begin
                mm = 1'b1;
                if (m_err != 5'd31) m_err = m_err + 5'd1;
                if (!m_fev) begin
                    m_fev = 1'b1;
                    m_fvec = vec;
                end
            end
            m_bitmap[vec] = 1'b1;
            if (&m_bitmap) m_state = 2;
        end
        e = '{mm, m_err, m_state == 2, (m_state == 2) && (m_err == 0), m_state == 1, m_fev, m_fvec};
        sb_q.push_back(e);
        @(posedge clk);
        #2;
        start = 1'b0; vec_valid = 1'b0;
    endtask

    task automatic model_reset();
        m_state = 0; m_bitmap = '0; m_err = '0; m_fev = 1'b0; m_fvec = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({o_busy, o_mismatch, o_err_count, o_first_err_valid, o_first_err_vec, o_done, o_pass} !== 15'd0) begin
            n_errors++;
            $display("FAIL reset_outputs got busy=%b err=%0d done=%b exp all zero", o_busy, o_err_count, o_done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        // samples in IDLE are ignored, even failing ones
        drive(0, 1, 4'h0, 1'b1);
        drive(0, 1, 4'h5, 1'b0);
    endtask

    task automatic test_binary_sweep();
        drive(1, 0, 4'h0, 1'b0);
        pulse_cnt = 0;
        for (int i = 0; i < 16; i++) drive(0, 1, 4'(i), golden(4'(i)));
        n_checks++;
        if (o_done !== 1'b1 || o_pass !== 1'b1 || o_err_count !== 5'd0 || pulse_cnt != 0) begin
            n_errors++;
            $display("FAIL binary_sweep got done=%b pass=%b err=%0d pulses=%0d exp 1 1 0 0", o_done, o_pass, o_err_count, pulse_cnt);
        end
        // DONE freezes: further samples change nothing
        drive(0, 1, 4'h3, 1'b0);
    endtask

    task automatic test_stuck_at_1();
        logic [3:0] v;
        drive(1, 0, 4'h0, 1'b0);
        pulse_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            v = 4'(i ^ (i >> 1));
            drive(0, 1, v, golden(v) | (v == 4'h0));
        end
        n_checks++;
        if (pulse_cnt != 1 || o_err_count !== 5'd1 || o_first_err_vec !== 4'h0 || o_done !== 1'b1 || o_pass !== 1'b0) begin
            n_errors++;
            $display("FAIL stuck_at_1 got pulses=%0d err=%0d fvec=%h done=%b pass=%b exp 1 1 0 1 0", pulse_cnt, o_err_count, o_first_err_vec, o_done, o_pass);
        end
    endtask

    task automatic test_stuck_at_0();
        drive(1, 0, 4'h0, 1'b0);
        pulse_cnt = 0;
        for (int i = 0; i < 16; i++) drive(0, 1, 4'(i), 1'b0);
        n_checks++;
        if (o_err_count !== 5'd15 || o_first_err_vec !== 4'h1 || o_pass !== 1'b0 || pulse_cnt != 15) begin
            n_errors++;
            $display("FAIL stuck_at_0 got err=%0d fvec=%h pass=%b pulses=%0d exp 15 1 0 15", o_err_count, o_first_err_vec, o_pass, pulse_cnt);
        end
    endtask

    task automatic test_gaps_duplicates();
        drive(1, 0, 4'h0, 1'b0);
        for (int i = 0; i < 15; i++) begin
            if ($urandom_range(0, 1) == 1) drive(0, 0, 4'($urandom), 1'($urandom));
            drive(0, 1, 4'(i), golden(4'(i)));
        end
        drive(0, 1, 4'h7, 1'b1);
        drive(0, 1, 4'h7, 1'b1);
        n_checks++;
        if (o_busy !== 1'b1 || o_done !== 1'b0) begin
            n_errors++;
            $display("FAIL gaps_incomplete got busy=%b done=%b exp 1 0", o_busy, o_done);
        end
        drive(0, 1, 4'hF, 1'b1);
        n_checks++;
        if (o_done !== 1'b1 || o_pass !== 1'b1 || o_err_count !== 5'd0 || o_busy !== 1'b0) begin
            n_errors++;
            $display("FAIL gaps_complete got done=%b pass=%b err=%0d busy=%b exp 1 1 0 0", o_done, o_pass, o_err_count, o_busy);
        end
    endtask

    task automatic test_saturation();
        drive(1, 0, 4'h0, 1'b0);
        for (int i = 0; i < 40; i++) drive(0, 1, 4'h1, 1'b0);
        n_checks++;
        if (o_err_count !== 5'd31 || o_busy !== 1'b1 || o_mismatch !== 1'b1) begin
            n_errors++;
            $display("FAIL saturation got err=%0d busy=%b mm=%b exp 31 1 1", o_err_count, o_busy, o_mismatch);
        end
    endtask

    task automatic test_back_to_back_restart();
        drive(1, 0, 4'h0, 1'b0);
        for (int i = 0; i < 16; i++) drive(0, 1, 4'(i), golden(4'(i)));
        // start from DONE carrying a failing sample for vector 0
        drive(1, 1, 4'h0, 1'b1);
        n_checks++;
        if (o_busy !== 1'b1 || o_done !== 1'b0 || o_err_count !== 5'd0 || o_first_err_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL restart_clear got busy=%b done=%b err=%0d fev=%b exp 1 0 0 0", o_busy, o_done, o_err_count, o_first_err_valid);
        end
        for (int i = 1; i < 16; i++) drive(0, 1, 4'(i), golden(4'(i)));
        n_checks++;
        if (o_done !== 1'b0 || o_busy !== 1'b1) begin
            n_errors++;
            $display("FAIL restart_sample_dropped got done=%b busy=%b exp 0 1", o_done, o_busy);
        end
    endtask

    task automatic test_reset_mid_run();
        drive(1, 0, 4'h0, 1'b0);
        for (int i = 0; i < 8; i++) drive(0, 1, 4'(i), (i == 3) ? 1'b0 : golden(4'(i)));
        n_checks++;
        if (o_err_count !== 5'd1 || o_first_err_vec !== 4'h3) begin
            n_errors++;
            $display("FAIL pre_reset got err=%0d fvec=%h exp 1 3", o_err_count, o_first_err_vec);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({o_busy, o_mismatch, o_err_count, o_first_err_valid, o_first_err_vec, o_done, o_pass} !== 15'd0) begin
            n_errors++;
            $display("FAIL mid_run_reset got busy=%b err=%0d fev=%b exp all zero", o_busy, o_err_count, o_first_err_valid);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 1, 4'h2, 1'b0);
        drive(1, 0, 4'h0, 1'b0);
        for (int i = 15; i >= 0; i--) drive(0, 1, 4'(i), golden(4'(i)));
        n_checks++;
        if (o_pass !== 1'b1 || o_err_count !== 5'd0 || o_done !== 1'b1) begin
            n_errors++;
            $display("FAIL post_reset_sweep got pass=%b err=%0d done=%b exp 1 0 1", o_pass, o_err_count, o_done);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_binary_sweep();
        test_stuck_at_1();
        test_stuck_at_0();
        test_gaps_duplicates();
        test_saturation();
        test_back_to_back_restart();
        test_reset_mid_run();
        repeat (2) @(posedge clk);
        #3;
        if (sb_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain got %0d pending exp 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
